// File: rtl/riscv_cpu.sv
`default_nettype none
// ============================================================================
// Module   : riscv_cpu
// Purpose  : Single-cycle RV32I-subset core for simulation bring-up. Each
//            clock fetches one word from an internal ROM, executes it and
//            retires it. The core has a 32x32 register file and a
//            word-addressed data RAM, and no external bus.
// Ports    : clk    - system clock, all state updates on the rising edge
//            reset  - synchronous, active-high reset
//            pc     - current program counter (registered)
//            opcode - instr[6:0]   of the word at pc
//            rs1    - instr[19:15] of the word at pc
//            rs2    - instr[24:20] of the word at pc
//            rd     - instr[11:7]  of the word at pc
//            funct3 - instr[14:12] of the word at pc
// Params   : RESET_PC, IMEM_WORDS, DMEM_WORDS as named. USE_ROM_IMAGE=1
//            replaces the built-in program with ROM_IMAGE (word i is held
//            in ROM_IMAGE[32*i +: 32]).
// Revision : 1.0 - initial release
// ============================================================================
module riscv_cpu #(
  parameter logic [31:0]              RESET_PC      = 32'h0000_0000,
  parameter int                       IMEM_WORDS    = 64,
  parameter int                       DMEM_WORDS    = 64,
  parameter bit                       USE_ROM_IMAGE = 1'b0,
  parameter logic [IMEM_WORDS*32-1:0] ROM_IMAGE     = '0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  output logic [6:0]  opcode,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  funct3
);

  localparam int IW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int DW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Built-in bring-up program: computes 5+3 and 5-3, round-trips the sum
  // through RAM, and branches over the "addi x6" when the reload matches.
  function automatic logic [31:0] default_rom(input int idx);
    case (idx)
      0:       default_rom = 32'h0050_0093; // addi x1,x0,5
      1:       default_rom = 32'h0030_0113; // addi x2,x0,3
      2:       default_rom = 32'h0020_81B3; // add  x3,x1,x2
      3:       default_rom = 32'h4020_8233; // sub  x4,x1,x2
      4:       default_rom = 32'h0030_2023; // sw   x3,0(x0)
      5:       default_rom = 32'h0000_2283; // lw   x5,0(x0)
      6:       default_rom = 32'h0051_8463; // beq  x3,x5,+8
      7:       default_rom = 32'h0010_0313; // addi x6,x0,1
      8:       default_rom = 32'h0000_006F; // jal  x0,0
      default: default_rom = NOP_WORD;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Instruction ROM (constant contents)
  // --------------------------------------------------------------------------
  logic [31:0] rom [IMEM_WORDS];

  for (genvar gi = 0; gi < IMEM_WORDS; gi++) begin : g_rom
    assign rom[gi] = USE_ROM_IMAGE ? ROM_IMAGE[gi*32 +: 32] : default_rom(gi);
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0] pc_q;
  logic [31:0] regs [32];
  logic [31:0] dmem [DMEM_WORDS];

  // --------------------------------------------------------------------------
  // Fetch and decode
  // --------------------------------------------------------------------------
  logic [29:0] fetch_idx;
  logic [31:0] instr;
  logic [6:0]  funct7;

  assign fetch_idx = pc_q[31:2];

  always_comb begin
    instr = NOP_WORD;
    if ({2'b00, fetch_idx} < 32'(IMEM_WORDS))
      instr = rom[fetch_idx[IW-1:0]];
  end

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign pc     = pc_q;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // x0 is forced to read zero regardless of array contents.
  logic [31:0] rv1, rv2;

  assign rv1 = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rv2 = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  // --------------------------------------------------------------------------
  // Data memory addressing (word index = address[31:2])
  // --------------------------------------------------------------------------
  logic [31:0] mem_addr;
  logic [29:0] dmem_idx;
  logic        dmem_hit;
  logic [31:0] load_data;
  logic        unused_addr_bits;

  assign mem_addr         = rv1 + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign dmem_idx         = mem_addr[31:2];
  assign dmem_hit         = ({2'b00, dmem_idx} < 32'(DMEM_WORDS));
  assign load_data        = dmem_hit ? dmem[dmem_idx[DW-1:0]] : 32'd0;
  assign unused_addr_bits = ^mem_addr[1:0];

  // --------------------------------------------------------------------------
  // Execute: next pc, writeback and store enable
  // --------------------------------------------------------------------------
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        wb_en;
  logic [31:0] wb_data;
  logic        st_en;
  logic        taken;
  logic        br_valid;
  logic [31:0] op_b;
  logic [4:0]  shamt;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    next_pc  = pc_plus4;
    wb_en    = 1'b0;
    wb_data  = 32'd0;
    st_en    = 1'b0;
    taken    = 1'b0;
    br_valid = 1'b1;
    // OP-IMM and OP share one ALU; only the second operand differs.
    op_b     = (opcode == OPC_OP) ? rv2 : imm_i;
    shamt    = op_b[4:0];

    case (opcode)
      OPC_LUI: begin
        wb_en   = 1'b1;
        wb_data = imm_u;
      end
      OPC_AUIPC: begin
        wb_en   = 1'b1;
        wb_data = pc_q + imm_u;
      end
      OPC_JAL: begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        next_pc = pc_q + imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          wb_en   = 1'b1;
          wb_data = pc_plus4;
          next_pc = (rv1 + imm_i) & ~32'd1;
        end
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000:  taken = (rv1 == rv2);
          3'b001:  taken = (rv1 != rv2);
          3'b100:  taken = ($signed(rv1) <  $signed(rv2));
          3'b101:  taken = ($signed(rv1) >= $signed(rv2));
          3'b110:  taken = (rv1 <  rv2);
          3'b111:  taken = (rv1 >= rv2);
          default: br_valid = 1'b0;
        endcase
        if (br_valid && taken)
          next_pc = pc_q + imm_b;
      end
      OPC_LOAD: begin
        if (funct3 == 3'b010) begin
          wb_en   = 1'b1;
          wb_data = load_data;
        end
      end
      OPC_STORE: begin
        if (funct3 == 3'b010)
          st_en = dmem_hit;
      end
      OPC_OPIMM: begin
        wb_en = 1'b1;
        case (funct3)
          3'b000: wb_data = rv1 + op_b;
          3'b010: wb_data = {31'd0, $signed(rv1) < $signed(op_b)};
          3'b011: wb_data = {31'd0, rv1 < op_b};
          3'b100: wb_data = rv1 ^ op_b;
          3'b110: wb_data = rv1 | op_b;
          3'b111: wb_data = rv1 & op_b;
          3'b001: begin
            if (funct7 == 7'b0000000) wb_data = rv1 << shamt;
            else                      wb_en   = 1'b0;
          end
          default: begin // 3'b101
            if (funct7 == 7'b0000000)      wb_data = rv1 >> shamt;
            else if (funct7 == 7'b0100000) wb_data = $signed(rv1) >>> shamt;
            else                           wb_en   = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        wb_en = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: wb_data = rv1 + op_b;
          {7'b0100000, 3'b000}: wb_data = rv1 - op_b;
          {7'b0000000, 3'b001}: wb_data = rv1 << shamt;
          {7'b0000000, 3'b010}: wb_data = {31'd0, $signed(rv1) < $signed(op_b)};
          {7'b0000000, 3'b011}: wb_data = {31'd0, rv1 < op_b};
          {7'b0000000, 3'b100}: wb_data = rv1 ^ op_b;
          {7'b0000000, 3'b101}: wb_data = rv1 >> shamt;
          {7'b0100000, 3'b101}: wb_data = $signed(rv1) >>> shamt;
          {7'b0000000, 3'b110}: wb_data = rv1 | op_b;
          {7'b0000000, 3'b111}: wb_data = rv1 & op_b;
          default:              wb_en   = 1'b0;
        endcase
      end
      default: ; // unknown opcode retires as a NOP
    endcase
  end

  // --------------------------------------------------------------------------
  // Retire: pc, register file and data RAM all update on the same edge.
  // Reset takes priority, so an instruction in flight during reset is dropped.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 32; i++)
        regs[i] <= 32'd0;
    end else begin
      pc_q <= next_pc;
      if (wb_en && (rd != 5'd0))
        regs[rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DMEM_WORDS; i++)
        dmem[i] <= 32'd0;
    end else if (st_en) begin
      dmem[dmem_idx[DW-1:0]] <= rv2;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_cpu
// Purpose  : Self-checking bench for riscv_cpu. Instance dut_a runs the
//            built-in program; instance dut_b runs a program that exercises
//            x0 writes, RAM bounds, a few ALU ops, a signed branch and an
//            out-of-range fetch at 0x400.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_cpu;

  localparam int IMW = 64;

  function automatic logic [IMW*32-1:0] alt_image();
    logic [IMW*32-1:0] img;
    img = {IMW{32'h0000_0013}};
    img[ 0*32 +: 32] = 32'h0070_0013; // 0x00 addi x0,x0,7
    img[ 1*32 +: 32] = 32'h4000_0393; // 0x04 addi x7,x0,0x400
    img[ 2*32 +: 32] = 32'h0090_0413; // 0x08 addi x8,x0,9
    img[ 3*32 +: 32] = 32'h0080_2023; // 0x0C sw   x8,0(x0)
    img[ 4*32 +: 32] = 32'h0073_A023; // 0x10 sw   x7,0(x7)   out of range
    img[ 5*32 +: 32] = 32'h0003_A483; // 0x14 lw   x9,0(x7)   out of range
    img[ 6*32 +: 32] = 32'h0000_2503; // 0x18 lw   x10,0(x0)
    img[ 7*32 +: 32] = 32'h8000_05B7; // 0x1C lui  x11,0x80000
    img[ 8*32 +: 32] = 32'h4045_D613; // 0x20 srai x12,x11,4
    img[ 9*32 +: 32] = 32'h0005_A6B3; // 0x24 slt  x13,x11,x0
    img[10*32 +: 32] = 32'h00B4_3733; // 0x28 sltu x14,x8,x11
    img[11*32 +: 32] = 32'h0085_C463; // 0x2C blt  x11,x8,+8
    img[12*32 +: 32] = 32'h0010_0793; // 0x30 addi x15,x0,1  (skipped)
    img[13*32 +: 32] = 32'h3CC0_006F; // 0x34 jal  x0,0x400
    return img;
  endfunction

  localparam logic [IMW*32-1:0] ALT_IMAGE = alt_image();

  logic        clk = 1'b0;
  logic        reset_a, reset_b;
  logic [31:0] pc_a, pc_b;
  logic [6:0]  opcode_a, opcode_b;
  logic [4:0]  rs1_a, rs2_a, rd_a, rs1_b, rs2_b, rd_b;
  logic [2:0]  funct3_a, funct3_b;

  always #5 clk = ~clk;

  riscv_cpu dut_a (
    .clk(clk), .reset(reset_a), .pc(pc_a), .opcode(opcode_a),
    .rs1(rs1_a), .rs2(rs2_a), .rd(rd_a), .funct3(funct3_a)
  );

  riscv_cpu #(
    .USE_ROM_IMAGE(1'b1),
    .ROM_IMAGE(ALT_IMAGE)
  ) dut_b (
    .clk(clk), .reset(reset_b), .pc(pc_b), .opcode(opcode_b),
    .rs1(rs1_b), .rs2(rs2_b), .rd(rd_b), .funct3(funct3_b)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  op;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push the expected post-edge state, clock once, then pop and compare.
  task automatic step(input bit use_b, input logic [31:0] exp_pc,
                      input logic [6:0] exp_op, input string tag);
    exp_t e;
    e.pc = exp_pc;
    e.op = exp_op;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_pc"}, use_b ? pc_b : pc_a, e.pc);
    chk({tag, "_op"}, {25'd0, use_b ? opcode_b : opcode_a}, {25'd0, e.op});
  endtask

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  initial begin
    logic [31:0] acc;

    reset_a = 1'b1;
    reset_b = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset state and decode of word 0 (addi x1,x0,5)
    chk("rst_pc",     pc_a, 32'h0);
    chk("rst_opcode", {25'd0, opcode_a}, {25'd0, OP_IMM});
    chk("rst_rd",     {27'd0, rd_a},  32'd1);
    chk("rst_rs1",    {27'd0, rs1_a}, 32'd0);
    chk("rst_rs2",    {27'd0, rs2_a}, 32'd5);
    chk("rst_funct3", {29'd0, funct3_a}, 32'd0);

    // Default program
    reset_a = 1'b0;
    step(1'b0, 32'd4,  OP_IMM, "a1");
    step(1'b0, 32'd8,  OP_REG, "a2");
    chk("pc8_rd",     {27'd0, rd_a},  32'd3);
    chk("pc8_rs1",    {27'd0, rs1_a}, 32'd1);
    chk("pc8_rs2",    {27'd0, rs2_a}, 32'd2);
    chk("pc8_funct3", {29'd0, funct3_a}, 32'd0);
    step(1'b0, 32'd12, OP_REG, "a3");
    step(1'b0, 32'd16, OP_ST,  "a4");
    chk("pc16_rs1",    {27'd0, rs1_a}, 32'd0);
    chk("pc16_rs2",    {27'd0, rs2_a}, 32'd3);
    chk("pc16_funct3", {29'd0, funct3_a}, 32'd2);
    step(1'b0, 32'd20, OP_LD,  "a5");
    step(1'b0, 32'd24, OP_BR,  "a6");
    step(1'b0, 32'd32, OP_JAL, "a7");
    step(1'b0, 32'd32, OP_JAL, "a8");
    step(1'b0, 32'd32, OP_JAL, "a9");
    chk("pc32_rd", {27'd0, rd_a}, 32'd0);
    chk("a_x1", dut_a.regs[1], 32'd5);
    chk("a_x2", dut_a.regs[2], 32'd3);
    chk("a_x3", dut_a.regs[3], 32'd8);
    chk("a_x4", dut_a.regs[4], 32'd2);
    chk("a_x5", dut_a.regs[5], 32'd8);
    chk("a_x6", dut_a.regs[6], 32'd0);
    chk("a_mem0", dut_a.dmem[0], 32'd8);

    // Reset while parked at pc=32
    reset_a = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_pc", pc_a, 32'h0);
    acc = 32'd0;
    for (int i = 1; i < 32; i++) acc = acc | dut_a.regs[i];
    chk("midrst_regs_or", acc, 32'd0);
    chk("midrst_mem0", dut_a.dmem[0], 32'd0);
    reset_a = 1'b0;
    step(1'b0, 32'd4, OP_IMM, "restart");
    chk("restart_x1", dut_a.regs[1], 32'd5);

    // Alternate program
    reset_b = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      logic [6:0] op;
      case (k)
        3, 4:    op = OP_ST;
        5, 6:    op = OP_LD;
        7:       op = OP_LUI;
        9, 10:   op = OP_REG;
        11:      op = OP_BR;
        default: op = OP_IMM;
      endcase
      step(1'b1, 32'(4 * k), op, $sformatf("b%0d", k));
    end
    step(1'b1, 32'h34,  OP_JAL, "b_blt_taken");
    step(1'b1, 32'h400, OP_IMM, "b_oob0");
    step(1'b1, 32'h404, OP_IMM, "b_oob1");
    step(1'b1, 32'h408, OP_IMM, "b_oob2");
    step(1'b1, 32'h40C, OP_IMM, "b_oob3");

    chk("b_x0",  dut_b.regs[0],  32'd0);
    chk("b_x7",  dut_b.regs[7],  32'h400);
    chk("b_x8",  dut_b.regs[8],  32'd9);
    chk("b_x9_oob_load", dut_b.regs[9], 32'd0);
    chk("b_x10", dut_b.regs[10], 32'd9);
    chk("b_x11_lui",  dut_b.regs[11], 32'h8000_0000);
    chk("b_x12_srai", dut_b.regs[12], 32'hF800_0000);
    chk("b_x13_slt",  dut_b.regs[13], 32'd1);
    chk("b_x14_sltu", dut_b.regs[14], 32'd1);
    chk("b_x15_skip", dut_b.regs[15], 32'd0);
    chk("b_mem0", dut_b.dmem[0], 32'd9);
    acc = 32'd0;
    for (int i = 1; i < 64; i++) acc = acc | dut_b.dmem[i];
    chk("b_mem_rest_or", acc, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
